// File: rtl/grad_calc_p.sv
`default_nettype none
// ============================================================================
// grad_calc_p : streaming 3x3 central-difference gradients (dx vertical, dy horizontal)
// Revision 1.0
// ============================================================================
module grad_calc_p #(
  parameter  int DW    = 8,
  parameter  int IMG_W = 64,
  parameter  int IMG_H = 64,
  parameter  int NCH   = 2,
  parameter  int SAT   = 1,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  input  logic [DW-1:0]        din,
  input  logic                 sof,
  input  logic [CW-1:0]        ch_sel,
  output logic signed [DW-1:0] dx,
  output logic signed [DW-1:0] dy,
  output logic                 dout_valid,
  output logic [CW-1:0]        dout_ch,
  output logic                 sat_flag,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] C_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] R_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] C_TWO  = XW'(2);
  localparam logic [YW-1:0] R_TWO  = YW'(2);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_RUN = 2'd2} state_t;

  state_t        r_state, w_state_nxt;
  logic [XW-1:0] r_col, w_col_nxt, w_cur_c;
  logic [YW-1:0] r_row, w_row_nxt, w_cur_r;
  logic          w_start, w_act, w_abort, w_is_last, w_centre;

  logic [DW-1:0] r_lb1 [IMG_W];
  logic [DW-1:0] r_lb2 [IMG_W];
  logic [DW-1:0] r_top_n, r_top_c, r_bot_n, r_bot_c, r_mid_l, r_mid_c, r_mid_r;

  logic [CW-1:0] r_ch_lat, r_ch0, r_ch1;
  logic          r_v0, r_v1, r_last0, r_last1;
  logic [DW:0]   r_dx_d, r_dy_d;
  logic [DW-1:0] w_qx, w_qy;
  logic          w_sx, w_sy;

  assign w_start   = din_valid & sof;
  assign w_act     = din_valid & (sof | (r_state != S_IDLE));
  assign w_abort   = w_start & (r_state != S_IDLE);
  assign w_cur_c   = w_start ? '0 : r_col;
  assign w_cur_r   = w_start ? '0 : r_row;
  assign w_is_last = (w_cur_r == R_LAST) && (w_cur_c == C_LAST);
  // A window centred on an interior pixel is complete once column/row 2 arrive.
  assign w_centre  = w_act && !w_start && (w_cur_r >= R_TWO) && (w_cur_c >= C_TWO);

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    if (w_act) begin
      if (w_is_last) begin
        w_col_nxt = '0;
        w_row_nxt = '0;
      end else if (w_cur_c == C_LAST) begin
        w_col_nxt = '0;
        w_row_nxt = w_cur_r + YW'(1);
      end else begin
        w_col_nxt = w_cur_c + XW'(1);
        w_row_nxt = w_cur_r;
      end
    end
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_FILL;
      S_FILL: begin
        if (w_start) w_state_nxt = S_FILL;
        else if (w_act && (w_cur_r == R_TWO) && (w_cur_c == '0)) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_start) w_state_nxt = S_FILL;
        else if (w_act && w_is_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Buffers and window hold pixel data only; no result reads them before they are refilled.
  always_ff @(posedge clk) begin
    if (w_act) begin
      r_lb1[w_cur_c] <= din;
      r_lb2[w_cur_c] <= r_lb1[w_cur_c];
      r_top_n        <= r_lb2[w_cur_c];
      r_top_c        <= r_top_n;
      r_bot_n        <= din;
      r_bot_c        <= r_bot_n;
      r_mid_r        <= r_lb1[w_cur_c];
      r_mid_c        <= r_mid_r;
      r_mid_l        <= r_mid_c;
    end
  end

  always_comb begin
    w_sx = 1'b0;
    w_sy = 1'b0;
    w_qx = r_dx_d[DW-1:0];
    w_qy = r_dy_d[DW-1:0];
    if (SAT != 0) begin
      // A DW+1 bit value fits in DW bits iff its top two bits agree.
      w_sx = r_dx_d[DW] ^ r_dx_d[DW-1];
      w_sy = r_dy_d[DW] ^ r_dy_d[DW-1];
      if (w_sx) w_qx = {r_dx_d[DW], {(DW-1){~r_dx_d[DW]}}};
      if (w_sy) w_qy = {r_dy_d[DW], {(DW-1){~r_dy_d[DW]}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_row      <= '0;
      r_ch_lat   <= '0;
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
      r_last0    <= 1'b0;
      r_last1    <= 1'b0;
      r_ch0      <= '0;
      r_ch1      <= '0;
      r_dx_d     <= '0;
      r_dy_d     <= '0;
      dx         <= '0;
      dy         <= '0;
      dout_valid <= 1'b0;
      dout_ch    <= '0;
      sat_flag   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      if (w_start) r_ch_lat <= ch_sel;
      r_v0    <= w_centre;
      r_last0 <= w_centre & w_is_last;
      r_ch0   <= r_ch_lat;
      r_v1    <= r_v0 & ~w_abort;
      r_last1 <= r_last0;
      r_ch1   <= r_ch0;
      r_dx_d  <= {1'b0, r_bot_c} - {1'b0, r_top_c};
      r_dy_d  <= {1'b0, r_mid_r} - {1'b0, r_mid_l};
      dout_valid <= r_v1 & ~w_abort;
      frame_done <= r_v1 & r_last1 & ~w_abort;
      if (r_v1 & ~w_abort) begin
        dx       <= w_qx;
        dy       <= w_qy;
        sat_flag <= w_sx | w_sy;
        dout_ch  <= r_ch1;
      end
      // A frame started before the previous one drains keeps busy high.
      busy <= w_start | (busy & ~(frame_done & (r_state == S_IDLE)));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_grad_calc_p.sv
`default_nettype none
// tb_grad_calc_p: directed frames against a frame-image gradient model,
// one saturating and one truncating instance driven in parallel.
module tb_grad_calc_p;
  localparam int DW = 8, W = 5, H = 4, NCH = 2, CW = 1;

  logic clk = 1'b0, rst = 1'b0, din_valid = 1'b0, sof = 1'b0;
  logic [DW-1:0] din = '0;
  logic [CW-1:0] ch_sel = '0;
  logic [DW-1:0] dx1, dy1, dx0, dy0;
  logic dv1, dv0, sf1, sf0, fd1, fd0, bz1, bz0;
  logic [CW-1:0] ch1o, ch0o;

  grad_calc_p #(.DW(DW), .IMG_W(W), .IMG_H(H), .NCH(NCH), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .sof(sof), .ch_sel(ch_sel),
    .dx(dx1), .dy(dy1), .dout_valid(dv1), .dout_ch(ch1o), .sat_flag(sf1),
    .frame_done(fd1), .busy(bz1));

  grad_calc_p #(.DW(DW), .IMG_W(W), .IMG_H(H), .NCH(NCH), .SAT(0)) dut_trn (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .sof(sof), .ch_sel(ch_sel),
    .dx(dx0), .dy(dy0), .dout_valid(dv0), .dout_ch(ch0o), .sat_flag(sf0),
    .frame_done(fd0), .busy(bz0));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef struct { int due; int dxs; int dys; int sats; int dxt; int dyt; int ch; int fd; } res_t;
  typedef struct { int dxs; int dys; int sats; int dxt; int dyt; int satt; int ch; int fd; int edg; } obs_t;
  res_t q[$];
  obs_t lg[$];
  int img [H][W];
  int mr = 0, mc = 0, ch_m = 0;
  bit active = 0, busy_m = 0, fd_pend = 0, watch = 0;
  int busy_low = 0;

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      q.delete(); active = 0; busy_m = 0; fd_pend = 0; mr = 0; mc = 0;
    end else begin
      if (fd_pend && !(din_valid && sof) && !active) busy_m = 0;
      if (din_valid && sof) begin
        if (active) while (q.size() > 0 && q[q.size()-1].due >= cyc) void'(q.pop_back());
        active = 1; ch_m = int'(ch_sel); mr = 0; mc = 0; busy_m = 1;
      end
      if (din_valid && active) begin
        img[mr][mc] = int'(din);
        if (mr >= 2 && mc >= 2) begin
          res_t e;
          int vx, vy;
          vx = img[mr][mc-1] - img[mr-2][mc-1];
          vy = img[mr-1][mc] - img[mr-1][mc-2];
          e.due  = cyc + 2;
          e.dxs  = clamp8(vx) & 255;
          e.dys  = clamp8(vy) & 255;
          e.sats = (clamp8(vx) != vx || clamp8(vy) != vy) ? 1 : 0;
          e.dxt  = vx & 255;
          e.dyt  = vy & 255;
          e.ch   = ch_m;
          e.fd   = (mr - 1 == H - 2 && mc - 1 == W - 2) ? 1 : 0;
          q.push_back(e);
        end
        if (mr == H-1 && mc == W-1) active = 0;
        else if (mc == W-1) begin mc = 0; mr++; end
        else mc++;
      end
      fd_pend = (q.size() > 0 && q[0].due == cyc && q[0].fd == 1);
    end
  end

  always @(negedge clk) begin : cmp
    res_t e;
    bit ev;
    ev = (q.size() > 0 && q[0].due == cyc);
    if (ev) e = q.pop_front();
    check("valid_sat", int'(dv1), int'(ev));
    check("valid_trn", int'(dv0), int'(ev));
    check("done_sat", int'(fd1), (ev && e.fd == 1) ? 1 : 0);
    check("done_trn", int'(fd0), (ev && e.fd == 1) ? 1 : 0);
    check("busy_sat", int'(bz1), int'(busy_m));
    check("busy_trn", int'(bz0), int'(busy_m));
    if (ev && dv1) begin
      check("dx_sat", int'(dx1), e.dxs);
      check("dy_sat", int'(dy1), e.dys);
      check("satf_sat", int'(sf1), e.sats);
      check("ch_sat", int'(ch1o), e.ch);
    end
    if (ev && dv0) begin
      check("dx_trn", int'(dx0), e.dxt);
      check("dy_trn", int'(dy0), e.dyt);
      check("satf_trn", int'(sf0), 0);
      check("ch_trn", int'(ch0o), e.ch);
    end
    if (!rst)
      check("reset_zero", int'(|{dx1, dy1, dv1, ch1o, sf1, fd1, bz1, dx0, dy0, dv0, ch0o, sf0, fd0, bz0}), 0);
    if (watch && !bz1) busy_low++;
    if (dv1) begin
      obs_t o;
      o.dxs = int'(dx1); o.dys = int'(dy1); o.sats = int'(sf1);
      o.dxt = int'(dx0); o.dyt = int'(dy0); o.satt = int'(sf0);
      o.ch = int'(ch1o); o.fd = int'(fd1); o.edg = cyc;
      lg.push_back(o);
    end
  end

  // ---------------- stimulus ----------------
  int acc_e22 = 0;

  function automatic int pix(input int kind, input int r, input int c);
    if (kind == 0) return 10 * r + c;
    return (r == 2 && c == 2) ? 255 : 0;
  endfunction

  task automatic drive(input bit v, input bit s, input bit ch, input int d);
    @(negedge clk);
    #1;
    din_valid = v; sof = s; ch_sel = ch; din = 8'(d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0);
  endtask

  task automatic send_frame(input int kind, input bit ch, input bit gaps, input int npix);
    for (int i = 0; i < npix; i++) begin
      int r, c;
      r = i / W; c = i % W;
      if (gaps) for (int k = 0; k < 4 && $urandom_range(0, 1) == 1; k++) drive(0, 0, ch, 0);
      drive(1, i == 0, ch, pix(kind, r, c));
      if (r == 2 && c == 2) acc_e22 = cyc + 1;
    end
  endtask

  initial begin
    int m;
    int base_dx[6], base_dy[6];
    repeat (3) @(negedge clk);
    check("rst_valid", int'(dv1), 0);
    check("rst_busy", int'(bz1), 0);
    #1 rst = 1'b1;

    // ramp frame
    m = lg.size();
    send_frame(0, 0, 0, W*H); idle(6);
    check("ramp_count", lg.size() - m, 6);
    for (int i = 0; i < 6; i++) begin
      base_dx[i] = -1; base_dy[i] = -1;
      if (m + i < lg.size()) begin
        check("ramp_dx", lg[m+i].dxs, 20);
        check("ramp_dy", lg[m+i].dys, 2);
        check("ramp_fd", lg[m+i].fd, (i == 5) ? 1 : 0);
        base_dx[i] = lg[m+i].dxs; base_dy[i] = lg[m+i].dys;
      end
    end
    if (lg.size() > m) check("ramp_latency", lg[m].edg, acc_e22 + 2);

    // saturation frame
    m = lg.size();
    send_frame(1, 0, 0, W*H); idle(6);
    check("sat_count", lg.size() - m, 6);
    if (lg.size() - m >= 6) begin
      check("sat_c11_dx", lg[m].dxs, 0);
      check("sat_c12_dx", lg[m+1].dxs, 127);
      check("sat_c12_flag", lg[m+1].sats, 1);
      check("trn_c12_dx", lg[m+1].dxt, 255);
      check("trn_c12_flag", lg[m+1].satt, 0);
      check("sat_c23_dy", lg[m+5].dys, 128);
      check("trn_c23_dy", lg[m+5].dyt, 1);
    end

    // ramp with random input gaps
    m = lg.size();
    send_frame(0, 1, 1, W*H); idle(6);
    check("gap_count", lg.size() - m, 6);
    for (int i = 0; i < 6; i++)
      if (m + i < lg.size()) begin
        check("gap_dx", lg[m+i].dxs, base_dx[i]);
        check("gap_dy", lg[m+i].dys, base_dy[i]);
        check("gap_ch", lg[m+i].ch, 1);
      end

    // abort at pixel (2,3) by a new sof on channel 1
    m = lg.size();
    send_frame(0, 0, 0, 13);
    send_frame(0, 1, 0, W*H); idle(6);
    check("abort_count", lg.size() - m, 6);
    for (int i = m; i < lg.size(); i++) begin
      check("abort_ch", lg[i].ch, 1);
      check("abort_dx", lg[i].dxs, 20);
    end

    // reset at pixel (1,4), then data without sof
    send_frame(0, 0, 0, 9);
    @(negedge clk); #1; rst = 1'b0; din_valid = 1'b1; sof = 1'b0; din = 8'd14;
    @(negedge clk);
    check("midrst_busy", int'(bz1), 0);
    check("midrst_dx", int'(dx1), 0);
    #1 rst = 1'b1;
    m = lg.size();
    for (int i = 0; i < 10; i++) drive(1, 0, 0, 100 + i);
    idle(4);
    check("nosof_count", lg.size() - m, 0);
    check("nosof_outs", int'(|{dx1, dy1, dv1, ch1o, sf1, fd1, bz1}), 0);

    // back-to-back frames, second sof accepted in the frame_done cycle
    m = lg.size(); busy_low = 0;
    send_frame(0, 1, 0, W*H);
    watch = 1;
    idle(2);
    send_frame(0, 0, 0, W*H);
    idle(2);
    watch = 0;
    idle(6);
    check("b2b_count", lg.size() - m, 12);
    check("b2b_busy_low", busy_low, 0);
    if (lg.size() - m >= 12) begin
      check("b2b_fd1", lg[m+5].fd, 1);
      check("b2b_fd2", lg[m+11].fd, 1);
      check("b2b_ch1", lg[m+5].ch, 1);
      check("b2b_ch2", lg[m+6].ch, 0);
    end
    check("final_busy", int'(bz1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
